// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers; one byte per grant.
// Optional WAIT_BUSY watchdog is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         sysclk_in,
    input  logic                         nrst_in,
    input  logic [N_REQ-1:0]             req_valid_in,
    input  logic [N_REQ*DATA_BITS-1:0]   req_data_in,
    output logic [N_REQ-1:0]             req_ready_out,
    output logic [DATA_BITS-1:0]         tx_data_out,
    output logic                         data_rdy_out,
    input  logic                         tx_busy_in,
    input  logic                         tx_done_in,
    output logic [$clog2(N_REQ)-1:0]     grant_idx_out,
    output logic                         active_out,
    output logic                         err_out
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic                   done_q;
    logic [N_REQ-1:0]       ready_q;
    logic [DATA_BITS-1:0]   tx_data_q;
    logic                   data_rdy_q;
    logic [IDX_W-1:0]       grant_q;

    logic                   done_rise;
    logic                   winner_found;
    logic [IDX_W-1:0]       winner_idx;
    logic [IDX_W:0]         cand;
    logic                   do_grant;
    logic                   rdy_clear;
    logic                   timeout_hit;

    assign done_rise = tx_done_in & ~done_q;

    // Search upward from rr_ptr with wrap; the first valid requester wins.
    always_comb begin
        winner_found = 1'b0;
        winner_idx   = '0;
        cand         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!winner_found && req_valid_in[cand[IDX_W-1:0]]) begin
                winner_found = 1'b1;
                winner_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wait_cnt_q <= '0;
        end else if (do_grant) begin
            wait_cnt_q <= '0;
        end else if (state_q == WAIT_BUSY) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    // The edge that would bring the count to TIMEOUT_CYCLES is the timeout edge.
    assign timeout_hit = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == WAIT_BUSY) && !done_rise && !tx_busy_in && timeout_hit;
        end
    end

    assign err_out = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_out     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        do_grant  = 1'b0;
        rdy_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    do_grant = 1'b1;
                    state_d  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A done edge here means the busy phase was missed entirely.
                if (done_rise) begin
                    rdy_clear = 1'b1;
                    state_d   = IDLE;
                end else if (tx_busy_in) begin
                    rdy_clear = 1'b1;
                    state_d   = WAIT_DONE;
                end else if (timeout_hit) begin
                    rdy_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= tx_done_in;
        end
    end

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            rr_ptr_q   <= '0;
            ready_q    <= '0;
            tx_data_q  <= '0;
            data_rdy_q <= 1'b0;
            grant_q    <= '0;
        end else begin
            ready_q <= '0;
            if (do_grant) begin
                tx_data_q  <= req_data_in[int'(winner_idx)*DATA_BITS +: DATA_BITS];
                ready_q    <= N_REQ'(1) << winner_idx;
                grant_q    <= winner_idx;
                rr_ptr_q   <= (winner_idx == IDX_W'(N_REQ - 1)) ? '0 : winner_idx + IDX_W'(1);
                data_rdy_q <= 1'b1;
            end else if (rdy_clear) begin
                data_rdy_q <= 1'b0;
            end
        end
    end

    assign req_ready_out = ready_q;
    assign tx_data_out   = tx_data_q;
    assign data_rdy_out  = data_rdy_q;
    assign grant_idx_out = grant_q;
    assign active_out    = (state_q != IDLE);

    a_ready_onehot: assert property (@(posedge sysclk_in) disable iff (!nrst_in)
        $onehot0(ready_q));
    a_ready_single_cycle: assert property (@(posedge sysclk_in) disable iff (!nrst_in)
        (ready_q != '0) |=> (ready_q == '0));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed grant and byte sequences.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int GW    = 2;
    localparam int FRAME = 12;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   tx_data;
    logic           data_rdy;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [GW-1:0]  grant_idx;
    logic           active;
    logic           err;

    uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(W), .TIMEOUT_CYCLES(TMO)) dut (
        .sysclk_in     (clk),
        .nrst_in       (nrst),
        .req_valid_in  (req_valid),
        .req_data_in   (req_data),
        .req_ready_out (req_ready),
        .tx_data_out   (tx_data),
        .data_rdy_out  (data_rdy),
        .tx_busy_in    (tx_busy),
        .tx_done_in    (tx_done),
        .grant_idx_out (grant_idx),
        .active_out    (active),
        .err_out       (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // Producers: per-requester byte lists, valid held until accepted.
    logic [W-1:0] prod_data [N][8];
    int           prod_cnt [N];
    int           prod_idx [N];

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (prod_idx[i] < prod_cnt[i]);
            req_data[i*W +: W] = (prod_idx[i] < prod_cnt[i]) ? prod_data[i][prod_idx[i]] : '0;
        end
    endtask

    task automatic load(input int i, input logic [W-1:0] b);
        prod_data[i][prod_cnt[i]] = b;
        prod_cnt[i]++;
        refresh();
    endtask

    task automatic clear_producers();
        for (int i = 0; i < N; i++) begin
            prod_cnt[i] = 0;
            prod_idx[i] = 0;
        end
        refresh();
    endtask

    function automatic bit all_consumed();
        for (int i = 0; i < N; i++) if (prod_idx[i] < prod_cnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        clear_producers();
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) prod_idx[i]++;
            refresh();
        end
    end

    // Minimal uart_tx stand-in: busy for FRAME cycles, then a one-cycle done pulse.
    bit           uart_en = 1'b1;
    int           u_cnt = 0;
    logic [W-1:0] cap_q[$];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!nrst) begin
                tx_busy = 1'b0;
                tx_done = 1'b0;
                u_cnt   = 0;
            end else if (u_cnt == 0) begin
                tx_done = 1'b0;
                if (uart_en && data_rdy) begin
                    tx_busy = 1'b1;
                    u_cnt   = FRAME;
                    cap_q.push_back(tx_data);
                end
            end else begin
                u_cnt--;
                if (u_cnt == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end
        end
    end

    // Reference model: who owns the UART, whether it acknowledged, pointer after last grant.
    int           m_owner = -1;
    bit           m_acked = 1'b0;
    int           m_ptr = 0;
    int           m_wait = 0;
    bit           m_prev_done = 1'b0;
    logic [N-1:0] e_ready = '0;
    logic [W-1:0] e_data = '0;
    int           e_grant = 0;
    bit           e_rdy = 1'b0;
    bit           e_err = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge nrst);
            if (!nrst) begin
                m_owner = -1; m_acked = 1'b0; m_ptr = 0; m_wait = 0; m_prev_done = 1'b0;
                e_ready = '0; e_data = '0; e_grant = 0; e_rdy = 1'b0; e_err = 1'b0;
            end else begin
                bit rise;
                int w;
                rise    = tx_done && !m_prev_done;
                e_ready = '0;
                e_err   = 1'b0;
                if (m_owner < 0) begin
                    w = -1;
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    if (w >= 0) begin
                        e_ready    = '0;
                        e_ready[w] = 1'b1;
                        e_data     = req_data[w*W +: W];
                        e_grant    = w;
                        m_ptr      = (w + 1) % N;
                        e_rdy      = 1'b1;
                        m_owner    = w;
                        m_acked    = 1'b0;
                        m_wait     = 0;
                    end
                end else if (!m_acked) begin
                    if (rise) begin
                        m_owner = -1;
                        e_rdy   = 1'b0;
                    end else if (tx_busy) begin
                        m_acked = 1'b1;
                        e_rdy   = 1'b0;
                    end else begin
                        m_wait++;
`ifdef UART_ARB_TIMEOUT_EN
                        if (m_wait == TMO) begin
                            m_owner = -1;
                            e_rdy   = 1'b0;
                            e_err   = 1'b1;
                        end
`endif
                    end
                end else if (rise) begin
                    m_owner = -1;
                end
                m_prev_done = tx_done;
            end
        end
    end

    // Every-cycle comparison and grant logging, away from the active edge.
    int grant_log[$];
    int ready_cnt[N];

    initial begin
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        forever begin
            @(negedge clk);
            check("req_ready_out", 32'(req_ready), 32'(e_ready));
            check("tx_data_out", 32'(tx_data), 32'(e_data));
            check("grant_idx_out", 32'(grant_idx), 32'(e_grant));
            check("data_rdy_out", 32'(data_rdy), 32'(e_rdy));
            check("active_out", 32'(active), 32'(m_owner >= 0));
            check("err_out", 32'(err), 32'(e_err));
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    grant_log.push_back(i);
                    ready_cnt[i]++;
                end
            end
        end
    end

    int           exp_g[$];
    logic [W-1:0] exp_q[$];

    task automatic clear_logs();
        grant_log.delete();
        cap_q.delete();
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    task automatic verify_logs(input string name, input bit with_bytes);
        check({name, " grant count"}, 32'(grant_log.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size() && i < grant_log.size(); i++)
            check({name, " grant seq"}, 32'(grant_log[i]), 32'(exp_g[i]));
        if (with_bytes) begin
            check({name, " byte count"}, 32'(cap_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
                check({name, " byte seq"}, 32'(cap_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int c;
        c = 0;
        while (!(all_consumed() && u_cnt == 0 && !tx_busy && !tx_done && !data_rdy) && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) expire(name);
    endtask

    task automatic wait_busy(input string name, input int budget);
        int c;
        c = 0;
        while (!tx_busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) expire(name);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset req_ready_out", 32'(req_ready), 32'h0);
        check("reset tx_data_out", 32'(tx_data), 32'h0);
        check("reset data_rdy_out", 32'(data_rdy), 32'h0);
        check("reset grant_idx_out", 32'(grant_idx), 32'h0);
        check("reset active_out", 32'(active), 32'h0);
        check("reset err_out", 32'(err), 32'h0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Single request on requester 2.
        clear_logs();
        load(2, 8'hA5);
        wait_quiet("single", 200);
        @(negedge clk);
        exp_g = '{2};
        exp_q = '{8'hA5};
        verify_logs("single", 1'b1);
        check("single active after done", 32'(active), 32'h0);
        check("single ready pulses", 32'(ready_cnt[2]), 32'd1);

        // Round robin with all four valid; rr_ptr is 3 after the previous grant.
        // Load order: requester 3 alone first, so the six-grant run starts from 0.
        clear_logs();
        load(3, 8'h43);
        wait_quiet("rr prefix", 200);
        clear_logs();
        load(0, 8'h10); load(0, 8'h10);
        load(1, 8'h21); load(1, 8'h21);
        load(2, 8'h32); load(3, 8'h43);
        wait_quiet("round robin", 1000);
        exp_g = '{0, 1, 2, 3, 0, 1};
        exp_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21};
        verify_logs("round robin", 1'b1);

        // Wrap and skip: rr_ptr is 2, only 3 and 1 valid.
        clear_logs();
        load(3, 8'h3C); load(1, 8'h1E);
        wait_quiet("wrap skip", 400);
        exp_g = '{3, 1};
        exp_q = '{8'h3C, 8'h1E};
        verify_logs("wrap skip", 1'b1);
        check("wrap skip no pulse 0", 32'(ready_cnt[0]), 32'd0);
        check("wrap skip no pulse 2", 32'(ready_cnt[2]), 32'd0);

        // Busy window: requester 0 raises valid while requester 1 owns the UART.
        clear_logs();
        load(1, 8'h77);
        wait_busy("busy window busy", 50);
        repeat (2) @(negedge clk);
        load(0, 8'h55);
        repeat (3) @(negedge clk);
        check("busy window no early pulse", 32'(ready_cnt[0]), 32'd0);
        wait_quiet("busy window", 400);
        exp_g = '{1, 0};
        exp_q = '{8'h77, 8'h55};
        verify_logs("busy window", 1'b1);
        check("busy window pulses 0", 32'(ready_cnt[0]), 32'd1);

        // Reset mid-frame.
        clear_logs();
        load(0, 8'hAA); load(1, 8'hBB); load(2, 8'hCC); load(3, 8'hDD);
        wait_busy("midreset busy", 50);
        repeat (2) @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("midreset req_ready_out", 32'(req_ready), 32'h0);
        check("midreset tx_data_out", 32'(tx_data), 32'h0);
        check("midreset data_rdy_out", 32'(data_rdy), 32'h0);
        check("midreset grant_idx_out", 32'(grant_idx), 32'h0);
        check("midreset active_out", 32'(active), 32'h0);
        clear_producers();
        repeat (2) @(negedge clk);
        #2;
        nrst = 1'b1;
        @(negedge clk);
        clear_logs();
        load(0, 8'h01); load(1, 8'h02); load(2, 8'h03); load(3, 8'h04);
        wait_quiet("after reset", 800);
        exp_g = '{0, 1, 2, 3};
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        verify_logs("after reset", 1'b1);

        // No busy from the UART: rr_ptr is 0 so requester 2 wins alone.
        clear_logs();
        uart_en = 1'b0;
        load(2, 8'h99);
        begin
            int c;
            c = 0;
            while (!data_rdy && c < 20) begin
                @(negedge clk);
                c++;
            end
            if (c >= 20) expire("stall grant");
            check("stall grant idx", 32'(grant_idx), 32'd2);
`ifdef UART_ARB_TIMEOUT_EN
            c = 0;
            while (!err && c < 100) begin
                @(negedge clk);
                c++;
            end
            if (c >= 100) expire("timeout err");
            check("timeout latency", 32'(c), 32'd16);
            check("timeout data_rdy", 32'(data_rdy), 32'h0);
            check("timeout active", 32'(active), 32'h0);
            @(negedge clk);
            check("timeout err one cycle", 32'(err), 32'h0);
`else
            repeat (1000) @(negedge clk);
            check("stall data_rdy held", 32'(data_rdy), 32'h1);
            check("stall active held", 32'(active), 32'h1);
            check("stall no err", 32'(err), 32'h0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
